mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_W, default 16, data and address width in bits; it equals the shared SIZE_WORD constant.
REQ-002 Parameter MEM_LAT, default 2, memory access cycles per transfer; it SHALL be at least 1.
REQ-003 Parameter STARVE_LIM, default 3, the number of consecutive data grants that a pending fetch tolerates.
REQ-004 clk  in  1  clock; the block SHALL use one clock, rising edge.
REQ-005 reset_n  in  1  reset; it SHALL be asynchronous and active-low.
REQ-006 f_req  in  1  fetch request; the requester holds it until f_ready.
REQ-007 f_addr  in  WORD_W  fetch address.
REQ-008 f_rdata  out  WORD_W  fetched word; it is valid while f_ready is high.
REQ-009 f_ready  out  1  one-cycle completion pulse for a fetch.
REQ-010 d_req  in  1  data request; the requester holds it until d_ready.
REQ-011 d_we  in  1  1 = write, 0 = read.
REQ-012 d_addr  in  WORD_W  data address.
REQ-013 d_wdata  in  WORD_W  write data.
REQ-014 d_rdata  out  WORD_W  read word; it is valid while d_ready is high.
REQ-015 d_ready  out  1  one-cycle completion pulse for a data access.
REQ-016 readM  out  1  memory read strobe.
REQ-017 writeM  out  1  memory write strobe.
REQ-018 address  out  WORD_W  memory address.
REQ-019 data  inout  WORD_W  shared memory bus.
REQ-020 num_fetch  out  WORD_W  count of completed fetches.

Function
REQ-021 The FSM SHALL have two states, IDLE and BUSY.
REQ-022 In IDLE with any request sampled at a clock edge, the block SHALL latch the winner, address, we and wdata, and enter BUSY with the cycle counter at 0.
REQ-023 BUSY SHALL last exactly MEM_LAT cycles, holding readM (read) or writeM (write), and address constant at the latched value.
REQ-024 On the final BUSY edge the block SHALL capture data into the winner's rdata register, pulse the winner's ready for the following cycle, and return to IDLE.
REQ-025 Latency from the request-sampling edge to the ready cycle SHALL be MEM_LAT+1 cycles.
REQ-026 A request still high in the ready cycle SHALL be treated as a new request, which permits back-to-back accesses with no dead cycle.
REQ-027 The block SHALL drive the data bus with latched wdata only while writeM is high and hold it at high-Z otherwise.
REQ-028 readM and writeM SHALL never be high together, and both SHALL be low in IDLE.
REQ-029 Arbitration: on a tie, data SHALL win unless starve_cnt equals STARVE_LIM, in which case fetch SHALL win.
REQ-030 starve_cnt SHALL increment, saturating at STARVE_LIM, on each data grant made while f_req is high.
REQ-031 starve_cnt SHALL clear on each fetch grant.
REQ-032 num_fetch SHALL increment on each f_ready and wrap from 2^WORD_W-1 to 0.
REQ-033 rdata registers SHALL hold their last value between ready pulses.
REQ-034 On a write, the requester's rdata SHALL be left unchanged.
REQ-035 Requests that drop while BUSY SHALL NOT abort the current transfer.
REQ-036 With MEM_LAT=1, BUSY SHALL last exactly one cycle.

Reset
REQ-037 While reset_n is low: state=IDLE; readM=0; writeM=0; address=0; data bus high-Z; f_ready=0; d_ready=0; f_rdata=0; d_rdata=0; starve_cnt=0; num_fetch=0.
REQ-038 Reset asserted mid-BUSY SHALL abort the transfer immediately, with strobes low asynchronously, and SHALL produce no ready pulse after release.

Structure
REQ-039 WORD_W default, the state encoding and the strobe polarities SHALL live in the shared header package beside SIZE_WORD.
REQ-040 The starvation counter SHALL be a natural sub-module, named arb_starve_counter.
REQ-041 The remainder of the block SHALL be one module, with no other sub-modules.

Verification
REQ-042 Scenario: f_req alone, f_addr=0x0010, memory returns 0xA5A5, MEM_LAT=2 -> readM high 2 cycles, f_ready in cycle 3 with f_rdata=0xA5A5, num_fetch=1.
REQ-043 Scenario: d_req, d_we=1, d_addr=0x0020, d_wdata=0x1234 -> writeM high 2 cycles with data=0x1234 on the bus, d_ready pulse, data high-Z afterwards.
REQ-044 Scenario: f_req and d_req held continuously, STARVE_LIM=3 -> grant order D,D,D,F,D,D,D,F with no dead cycles between transfers.
REQ-045 Scenario: reset_n low during the 2nd BUSY cycle -> readM=0 immediately, no ready after release, num_fetch=0.
REQ-046 Scenario: MEM_LAT=1, 2^WORD_W+1 fetches -> num_fetch=1 after the wrap, each ready 2 cycles after its request.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: word size, FSM encoding,
// strobe polarities and the tie-break rule.
package mem_arbiter_pkg;

    localparam int SIZE_WORD  = 16;
    localparam int WORD_W_DEF = SIZE_WORD;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic STROBE_ON  = 1'b1;
    localparam logic STROBE_OFF = 1'b0;

    // Data wins a tie unless the fetch side has been passed over too often.
    function automatic logic fetch_wins(input logic f_req, input logic d_req, input logic starved);
        return f_req & (~d_req | starved);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle: one fetch port and one data port.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);
    logic              f_req;
    logic [WORD_W-1:0] f_addr;
    logic [WORD_W-1:0] f_rdata;
    logic              f_ready;
    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [WORD_W-1:0] d_rdata;
    logic              d_ready;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        input  f_rdata, f_ready, d_rdata, d_ready
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        output f_rdata, f_ready, d_rdata, d_ready
    );
endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants taken while a fetch was waiting; saturates at LIM.
module arb_starve_counter #(
    parameter int LIM = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic starved
);
    localparam int              CNT_W = (LIM > 0) ? $clog2(LIM + 1) : 1;
    localparam logic [CNT_W-1:0] LIM_V = CNT_W'(LIM);

    logic [CNT_W-1:0] cnt_r;

    // Starvation count: cleared by a fetch grant, bumped by a contested data grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != LIM_V)) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign starved = (cnt_r == LIM_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one transfer at a time, fixed MEM_LAT-cycle access,
// data priority with bounded fetch starvation.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_arbiter_if.slave      bus,
    output logic              readM,
    output logic              writeM,
    output logic [WORD_W-1:0] address,
    inout  wire  [WORD_W-1:0] data,
    output logic [WORD_W-1:0] num_fetch
);
    localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    arb_state_t        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              fetch_win_r;
    logic              we_r;
    logic [WORD_W-1:0] wdata_r;
    logic [WORD_W-1:0] f_rdata_r;
    logic [WORD_W-1:0] d_rdata_r;
    logic              f_ready_r;
    logic              d_ready_r;

    logic any_req_s;
    logic grant_s;
    logic fetch_win_s;
    logic we_s;
    logic starved_s;
    logic starve_inc_s;
    logic starve_clr_s;

    assign any_req_s    = bus.f_req | bus.d_req;
    assign grant_s      = (state_r == IDLE) & any_req_s;
    assign fetch_win_s  = fetch_wins(bus.f_req, bus.d_req, starved_s);
    assign we_s         = ~fetch_win_s & bus.d_we;
    assign starve_inc_s = grant_s & ~fetch_win_s & bus.f_req;
    assign starve_clr_s = grant_s & fetch_win_s;

    arb_starve_counter #(
        .LIM (STARVE_LIM)
    ) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (starve_inc_s),
        .clr     (starve_clr_s),
        .starved (starved_s)
    );

    // Transfer FSM: grant in IDLE, hold strobes for MEM_LAT cycles, then pulse ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            fetch_win_r <= 1'b0;
            we_r        <= 1'b0;
            wdata_r     <= '0;
            address     <= '0;
            readM       <= STROBE_OFF;
            writeM      <= STROBE_OFF;
            f_rdata_r   <= '0;
            d_rdata_r   <= '0;
            f_ready_r   <= 1'b0;
            d_ready_r   <= 1'b0;
            num_fetch   <= '0;
        end else begin
            f_ready_r <= 1'b0;
            d_ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r     <= BUSY;
                        cnt_r       <= '0;
                        fetch_win_r <= fetch_win_s;
                        we_r        <= we_s;
                        wdata_r     <= bus.d_wdata;
                        address     <= fetch_win_s ? bus.f_addr : bus.d_addr;
                        readM       <= we_s ? STROBE_OFF : STROBE_ON;
                        writeM      <= we_s ? STROBE_ON : STROBE_OFF;
                    end else begin
                        readM  <= STROBE_OFF;
                        writeM <= STROBE_OFF;
                    end
                end
                BUSY: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE;
                        readM   <= STROBE_OFF;
                        writeM  <= STROBE_OFF;
                        if (fetch_win_r) begin
                            f_ready_r <= 1'b1;
                            f_rdata_r <= data;
                            num_fetch <= num_fetch + 1'b1;
                        end else begin
                            d_ready_r <= 1'b1;
                            // A write leaves the data requester's read word untouched.
                            if (!we_r) begin
                                d_rdata_r <= data;
                            end else begin
                                d_rdata_r <= d_rdata_r;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    readM   <= STROBE_OFF;
                    writeM  <= STROBE_OFF;
                end
            endcase
        end
    end

    assign data        = (writeM == STROBE_ON) ? wdata_r : {WORD_W{1'bz}};
    assign bus.f_rdata = f_rdata_r;
    assign bus.f_ready = f_ready_r;
    assign bus.d_rdata = d_rdata_r;
    assign bus.d_ready = d_ready_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a MEM_LAT=2 instance for the main
// scenarios and a narrow MEM_LAT=1 instance for the num_fetch wrap.
module tb_mem_arbiter;

    logic clk;
    logic reset_n;
    logic probe_en;
    int   n_checks;
    int   n_fail;

    mem_arbiter_if #(.WORD_W(16)) bus_a ();
    mem_arbiter_if #(.WORD_W(4))  bus_b ();

    logic        readM_a, writeM_a;
    logic [15:0] address_a, num_fetch_a;
    wire  [15:0] data_a;
    logic        readM_b, writeM_b;
    logic [3:0]  address_b, num_fetch_b;
    wire  [3:0]  data_b;

    // Memory models: return address-derived words while readM is high.
    assign data_a = readM_a ? (address_a ^ 16'hA5B5) : (probe_en ? 16'h5A5A : 16'hzzzz);
    assign data_b = readM_b ? (address_b ^ 4'h5) : 4'hz;

    mem_arbiter #(.WORD_W(16), .MEM_LAT(2), .STARVE_LIM(3)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus_a.slave),
        .readM     (readM_a),
        .writeM    (writeM_a),
        .address   (address_a),
        .data      (data_a),
        .num_fetch (num_fetch_a)
    );

    mem_arbiter #(.WORD_W(4), .MEM_LAT(1), .STARVE_LIM(3)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus_b.slave),
        .readM     (readM_b),
        .writeM    (writeM_b),
        .address   (address_b),
        .data      (data_b),
        .num_fetch (num_fetch_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (bus_a.f_ready || bus_a.d_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         ok;
        bit         saw_ready;
        logic [3:0] exp_b;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        probe_en = 1'b1;
        bus_a.f_req = 1'b0; bus_a.f_addr = 16'h0; bus_a.d_req = 1'b0;
        bus_a.d_we  = 1'b0; bus_a.d_addr = 16'h0; bus_a.d_wdata = 16'h0;
        bus_b.f_req = 1'b0; bus_b.f_addr = 4'h0;  bus_b.d_req = 1'b0;
        bus_b.d_we  = 1'b0; bus_b.d_addr = 4'h0;  bus_b.d_wdata = 4'h0;

        // Reset state
        repeat (2) cyc();
        check_val("rst_readM",   readM_a,       1'b0);
        check_val("rst_writeM",  writeM_a,      1'b0);
        check_val("rst_address", address_a,     16'h0000);
        check_val("rst_bus_hiz", data_a,        16'h5A5A);
        check_val("rst_f_ready", bus_a.f_ready, 1'b0);
        check_val("rst_d_ready", bus_a.d_ready, 1'b0);
        check_val("rst_f_rdata", bus_a.f_rdata, 16'h0000);
        check_val("rst_d_rdata", bus_a.d_rdata, 16'h0000);
        check_val("rst_nfetch",  num_fetch_a,   16'h0000);
        reset_n  = 1'b1;
        probe_en = 1'b0;
        cyc();

        // Single fetch, MEM_LAT=2
        bus_a.f_req = 1'b1; bus_a.f_addr = 16'h0010;
        cyc();
        check_val("f_busy1_readM",  readM_a,       1'b1);
        check_val("f_busy1_writeM", writeM_a,      1'b0);
        check_val("f_busy1_addr",   address_a,     16'h0010);
        check_val("f_busy1_ready",  bus_a.f_ready, 1'b0);
        cyc();
        check_val("f_busy2_readM",  readM_a,       1'b1);
        check_val("f_busy2_addr",   address_a,     16'h0010);
        cyc();
        check_val("f_rdy_readM",    readM_a,       1'b0);
        check_val("f_rdy_pulse",    bus_a.f_ready, 1'b1);
        check_val("f_rdy_rdata",    bus_a.f_rdata, 16'hA5A5);
        check_val("f_rdy_nfetch",   num_fetch_a,   16'h0001);
        bus_a.f_req = 1'b0;
        cyc();
        check_val("f_after_ready",  bus_a.f_ready, 1'b0);
        check_val("f_rdata_hold",   bus_a.f_rdata, 16'hA5A5);

        // Data write
        bus_a.d_req = 1'b1; bus_a.d_we = 1'b1; bus_a.d_addr = 16'h0020; bus_a.d_wdata = 16'h1234;
        cyc();
        check_val("w_busy1_writeM", writeM_a,  1'b1);
        check_val("w_busy1_readM",  readM_a,   1'b0);
        check_val("w_busy1_data",   data_a,    16'h1234);
        check_val("w_busy1_addr",   address_a, 16'h0020);
        cyc();
        check_val("w_busy2_writeM", writeM_a,  1'b1);
        check_val("w_busy2_data",   data_a,    16'h1234);
        cyc();
        check_val("w_rdy_writeM",   writeM_a,      1'b0);
        check_val("w_rdy_pulse",    bus_a.d_ready, 1'b1);
        check_val("w_rdy_rdata",    bus_a.d_rdata, 16'h0000);
        bus_a.d_req = 1'b0;
        probe_en    = 1'b1;
        #1;
        check_val("w_bus_hiz",      data_a,        16'h5A5A);
        probe_en = 1'b0;

        // Data read
        bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 16'h0030;
        repeat (3) cyc();
        check_val("r_rdy_pulse",    bus_a.d_ready, 1'b1);
        check_val("r_rdy_rdata",    bus_a.d_rdata, 16'hA585);
        bus_a.d_req = 1'b0;
        cyc();
        check_val("r_after_ready",  bus_a.d_ready, 1'b0);
        check_val("r_rdata_hold",   bus_a.d_rdata, 16'hA585);

        // Contention: expect D,D,D,F,D,D,D,F back to back
        bus_a.f_req = 1'b1; bus_a.f_addr = 16'h0050;
        bus_a.d_req = 1'b1; bus_a.d_addr = 16'h0040;
        cyc();
        check_val("arb_first_addr", address_a, 16'h0040);
        for (int i = 0; i < 8; i++) begin
            wait_ready(ok);
            check_val("arb_ready_seen", ok, 1'b1);
            check_val("arb_grant_is_f", bus_a.f_ready, ((i % 4) == 3));
            if (i == 7) begin
                bus_a.f_req = 1'b0;
                bus_a.d_req = 1'b0;
            end
            cyc();
            if (i < 7) begin
                check_val("arb_no_dead", readM_a, 1'b1);
            end
        end
        check_val("arb_nfetch", num_fetch_a, 16'h0003);

        // Reset during the second BUSY cycle
        bus_a.f_req = 1'b1; bus_a.f_addr = 16'h0060;
        cyc();
        cyc();
        check_val("rb_busy2_readM", readM_a, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rb_async_readM", readM_a,     1'b0);
        check_val("rb_nfetch",      num_fetch_a, 16'h0000);
        bus_a.f_req = 1'b0;
        cyc();
        reset_n   = 1'b1;
        saw_ready = 1'b0;
        repeat (4) begin
            cyc();
            if (bus_a.f_ready || bus_a.d_ready) saw_ready = 1'b1;
        end
        check_val("rb_no_ready",    saw_ready,   1'b0);
        check_val("rb_nfetch_post", num_fetch_a, 16'h0000);

        // MEM_LAT=1, 4-bit counter: 17 fetches wrap num_fetch to 1
        for (int i = 1; i <= 17; i++) begin
            bus_b.f_req  = 1'b1;
            bus_b.f_addr = 4'(i);
            exp_b        = 4'(i) ^ 4'h5;
            cyc();
            check_val("w1_busy_readM", readM_b, 1'b1);
            cyc();
            check_val("w1_ready",      bus_b.f_ready, 1'b1);
            check_val("w1_rdata",      bus_b.f_rdata, exp_b);
            check_val("w1_rdy_readM",  readM_b,       1'b0);
            bus_b.f_req = 1'b0;
            if (i == 16) begin
                check_val("w1_wrap_zero", num_fetch_b, 4'h0);
            end
            cyc();
        end
        check_val("w1_nfetch_final", num_fetch_b, 4'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
